if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS pipeline.
- Holds the PC and drives the instruction-memory address. Reads the word back combinationally and registers it with PC+4 into the IF/ID pipeline register.
- if_id_opcode feeds the main control decoder's opcode input directly.
- Handles branch redirect, load-use stall, a halt word, and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (word aligned).
- HALT_WORD, 32'hFC000000, instruction encoding (opcode 6'b111111) that stops fetch.
- CNT_WIDTH, 16, width of fetch_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc.
- imem_data  input  32  instruction word at imem_addr, combinational, same cycle.
- stall  input  1  hazard unit: hold PC and IF/ID.
- branch_taken  input  1  branch/bne resolved taken this cycle.
- branch_target  input  32  redirect address; bits [1:0] ignored.
- if_id_instr  output  32  registered instruction.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- if_id_opcode  output  6  if_id_instr[31:26], to the control decoder.
- halted  output  1  1 while in HALT state.
- fetch_count  output  CNT_WIDTH  count of valid instructions loaded into IF/ID.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC
  - if_id_instr = 0, if_id_pc_plus4 = 0, if_id_valid = 0
  - halted = 0, fetch_count = 0, state = RUN
- Reset dominates every other input and can interrupt any state, including HALT or a stall.
- Bubble = if_id_instr 32'h00000000 with if_id_valid 0. Opcode 000000 decodes as a harmless sll $0.
- Latency: the word at pc appears on if_id_instr one edge later. The decoder sees its opcode in that following cycle.
- PC arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC -> 0). The redirect target is {branch_target[31:2], 2'b00}.
- State RUN, per edge, in priority order:
  1. branch_taken=1 (even when stall=1): pc <= target; IF/ID <= bubble (flushes the wrong-path instruction); count unchanged.
  2. stall=1: pc and all IF/ID registers hold; count unchanged.
  3. imem_data == HALT_WORD: IF/ID <= bubble; pc holds; state <= HALT; halted <= 1. The halt word is never forwarded.
  4. Otherwise: if_id_instr <= imem_data; if_id_pc_plus4 <= pc+4; if_id_valid <= 1; pc <= pc+4; fetch_count increments.
- State HALT:
  - pc and IF/ID hold; if_id_valid stays 0; stall has no effect.
  - branch_taken=1 means an older branch put the halt on the wrong path. Then: pc <= target; state <= RUN; halted <= 0; IF/ID stays bubble.
- fetch_count saturates at all-ones and does not wrap.
- No X propagation: every register has an explicit value under reset and in each branch of the priority list.

Test Plan:
- Reset with imem holding 0x8C010004 (lw) at 0x0 and 0x20220001 (addi) at 0x4. Release reset -> edge 1: if_id_instr=0x8C010004, opcode=100011, pc_plus4=0x4, valid=1. Edge 2: 0x20220001, pc=0x8, fetch_count=2.
- stall=1 for 3 cycles at pc=0x8 -> pc, if_id_instr and fetch_count unchanged for all 3 edges. Fetch resumes from 0x8 on the next edge.
- branch_taken=1 with target 0x43 and stall=1 at the same time -> pc=0x40 after the edge; IF/ID is a bubble (instr 0, valid 0). The next edge fetches the word at 0x40.
- 0xFC000000 at 0x10 -> after the edge halted=1, valid=0, pc stays 0x10 for 5+ cycles. Then branch_taken to 0x20 -> halted=0 and the fetch at 0x20 proceeds.
- Preload pc=0xFFFFFFFC by reset with RESET_PC=0xFFFFFFFC -> the first fetch gives pc_plus4=0x0 and pc wraps to 0x0.
- Assert reset mid-stall and mid-HALT -> all outputs return to their reset values after one edge. fetch_count=0; saturation is checked with CNT_WIDTH=2: it stops at 3.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally and loads the
// IF/ID pipeline register; handles branch redirect, load-use stall, halt word and fetch counting.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [5:0]           if_id_opcode,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam int unsigned        WORD_W  = 32;
  localparam logic [WORD_W-1:0]  PC_STEP = WORD_W'(4);
  localparam logic [WORD_W-1:0]  ALIGN   = ~WORD_W'(3);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    pc_q, pc_d;
  logic [WORD_W-1:0]    instr_q, instr_d;
  logic [WORD_W-1:0]    pc_plus4_q, pc_plus4_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [WORD_W-1:0]    seq_pc;
  logic [WORD_W-1:0]    redirect_pc;

  // Sequential PC wraps naturally at 2^32; redirect drops the byte offset.
  assign seq_pc      = pc_q + PC_STEP;
  assign redirect_pc = branch_target & ALIGN;

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: everything holds unless a rule below fires.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    count_d    = count_q;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall so the wrong-path word is flushed.
          pc_d       = redirect_pc;
          instr_d    = '0;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
        end else if (!stall) begin
          if (imem_data == HALT_WORD) begin
            instr_d    = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
            halted_d   = 1'b1;
            state_d    = ST_HALT;
          end else begin
            instr_d    = imem_data;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
            pc_d       = seq_pc;
            if (count_q != CNT_MAX) begin
              count_d = count_q + CNT_WIDTH'(1);
            end
          end
        end
      end

      ST_HALT: begin
        // Only an older taken branch can pull fetch out of halt.
        if (branch_taken) begin
          pc_d       = redirect_pc;
          instr_d    = '0;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
          halted_d   = 1'b0;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_valid    = valid_q;
  assign if_id_opcode   = instr_q[31:26];
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan steps plus randomized
// stall/branch/reset traffic against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters. Instance B: wrapping reset PC, 2-bit counter.
  logic        reset_a, stall_a, br_a;
  logic [31:0] tgt_a, addr_a, data_a, instr_a, pc4_a;
  logic        valid_a, halted_a;
  logic [5:0]  op_a;
  logic [15:0] cnt_a;

  logic        reset_b, stall_b, br_b;
  logic [31:0] tgt_b, addr_b, data_b, instr_b, pc4_b;
  logic        valid_b, halted_b;
  logic [5:0]  op_b;
  logic [1:0]  cnt_b;

  logic [31:0] mem [64];

  assign data_a = mem[addr_a[7:2]];
  assign data_b = mem[addr_b[7:2]];

  if_stage dut_a (
    .clk(clk), .reset(reset_a), .imem_addr(addr_a), .imem_data(data_a),
    .stall(stall_a), .branch_taken(br_a), .branch_target(tgt_a),
    .if_id_instr(instr_a), .if_id_pc_plus4(pc4_a), .if_id_valid(valid_a),
    .if_id_opcode(op_a), .halted(halted_a), .fetch_count(cnt_a)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .HALT_WORD(32'hFC00_0000), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset_b), .imem_addr(addr_b), .imem_data(data_b),
    .stall(stall_b), .branch_taken(br_b), .branch_target(tgt_b),
    .if_id_instr(instr_b), .if_id_pc_plus4(pc4_b), .if_id_valid(valid_b),
    .if_id_opcode(op_b), .halted(halted_b), .fetch_count(cnt_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    int unsigned cnt;
  } model_t;

  model_t m [2];
  int vectors = 0;
  int miscompares = 0;

  function automatic int unsigned cnt_max(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  // Architectural fetch rules, one clock edge at a time.
  function automatic model_t model_next(input model_t c, input int i,
                                        input bit r, input bit s, input bit b,
                                        input logic [31:0] t);
    model_t n;
    logic [31:0] d;
    n = c;
    if (r) begin
      n.pc = (i == 0) ? 32'h0 : 32'hFFFF_FFFC;
      n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0; n.halted = 1'b0; n.cnt = 0;
    end else if (c.halted) begin
      if (b) begin
        n.pc = {t[31:2], 2'b00};
        n.halted = 1'b0;
      end
    end else if (b) begin
      n.pc = {t[31:2], 2'b00};
      n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0;
    end else if (!s) begin
      d = mem[c.pc[7:2]];
      if (d == HALT) begin
        n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0; n.halted = 1'b1;
      end else begin
        n.instr = d;
        n.pc4 = c.pc + 32'd4;
        n.pc = c.pc + 32'd4;
        n.valid = 1'b1;
        if (c.cnt < cnt_max(i)) n.cnt = c.cnt + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int i, input string lbl);
    logic [31:0] a, ins, p4, cn;
    logic v, h;
    logic [5:0] op;
    if (i == 0) begin
      a = addr_a; ins = instr_a; p4 = pc4_a; v = valid_a; h = halted_a; op = op_a; cn = 32'(cnt_a);
    end else begin
      a = addr_b; ins = instr_b; p4 = pc4_b; v = valid_b; h = halted_b; op = op_b; cn = 32'(cnt_b);
    end
    chk({lbl, ".pc"}, a, m[i].pc);
    chk({lbl, ".instr"}, ins, m[i].instr);
    chk({lbl, ".valid"}, 32'(v), 32'(m[i].valid));
    chk({lbl, ".opcode"}, 32'(op), 32'(m[i].instr[31:26]));
    chk({lbl, ".halted"}, 32'(h), 32'(m[i].halted));
    chk({lbl, ".count"}, cn, 32'(m[i].cnt));
    if (m[i].valid) chk({lbl, ".pc_plus4"}, p4, m[i].pc4);
  endtask

  task automatic step(input int i, input string lbl, input bit r, input bit s,
                      input bit b, input logic [31:0] t);
    model_t nxt;
    if (i == 0) begin
      reset_a = r; stall_a = s; br_a = b; tgt_a = t;
    end else begin
      reset_b = r; stall_b = s; br_b = b; tgt_b = t;
    end
    nxt = model_next(m[i], i, r, s, b, t);
    @(posedge clk);
    #1;
    m[i] = nxt;
    check_dut(i, lbl);
  endtask

  task automatic fill_mem(input int halt_odds);
    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom;
      if (mem[k] == HALT) mem[k] = mem[k] ^ 32'h1;
      if (halt_odds > 0 && ($urandom % halt_odds) == 0) mem[k] = HALT;
    end
  endtask

  initial begin
    reset_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; tgt_a = 32'h0;
    reset_b = 1'b1; stall_b = 1'b0; br_b = 1'b0; tgt_b = 32'h0;
    m[0] = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0, cnt: 0};
    m[1] = m[0];
    fill_mem(0);
    mem[0] = 32'h8C01_0004;
    mem[1] = 32'h2022_0001;
    mem[4] = HALT;

    // Reset and first two fetches.
    step(0, "rst", 1, 0, 0, 32'h0);
    step(0, "f0", 0, 0, 0, 32'h0);
    chk("tp.lw_instr", instr_a, 32'h8C01_0004);
    chk("tp.lw_opcode", 32'(op_a), 32'(6'b100011));
    step(0, "f1", 0, 0, 0, 32'h0);
    chk("tp.pc_after2", addr_a, 32'h8);

    // Three-cycle stall then resume at 0x8.
    for (int k = 0; k < 3; k++) step(0, "stall", 0, 1, 0, 32'h0);
    step(0, "resume", 0, 0, 0, 32'h0);

    // Branch wins over stall; target low bits dropped.
    step(0, "br_stall", 0, 1, 1, 32'h43);
    chk("tp.br_pc", addr_a, 32'h40);
    step(0, "fetch40", 0, 0, 0, 32'h0);

    // Enter halt at 0x10, sit there, then leave via branch.
    step(0, "br10", 0, 0, 1, 32'h10);
    step(0, "halt", 0, 0, 0, 32'h0);
    for (int k = 0; k < 6; k++) step(0, "halted", 0, k[0], 0, 32'h0);
    chk("tp.halt_pc", addr_a, 32'h10);
    step(0, "unhalt", 0, 0, 1, 32'h20);
    step(0, "fetch20", 0, 0, 0, 32'h0);

    // Reset mid-stall and mid-halt.
    step(0, "pre_st", 0, 1, 0, 32'h0);
    step(0, "rst_st", 1, 1, 0, 32'h0);
    for (int k = 0; k < 5; k++) step(0, "to_halt", 0, 0, 0, 32'h0);
    step(0, "rst_halt", 1, 1, 0, 32'h0);
    chk("tp.cnt_reset", 32'(cnt_a), 32'h0);

    // Wrap from 0xFFFFFFFC and 2-bit counter saturation.
    reset_a = 1'b1;
    step(1, "b_rst", 1, 0, 0, 32'h0);
    step(1, "b_wrap", 0, 0, 0, 32'h0);
    chk("tp.wrap_pc4", pc4_b, 32'h0);
    for (int k = 0; k < 4; k++) step(1, "b_sat", 0, 0, 0, 32'h0);
    chk("tp.sat_cnt", 32'(cnt_b), 32'h3);

    // Randomized traffic, halt words sprinkled through memory.
    for (int i = 0; i < 2; i++) begin
      fill_mem(12);
      step(i, "r_rst", 1, 0, 0, 32'h0);
      for (int k = 0; k < 300; k++) begin
        step(i, "rand", ($urandom % 50) == 0, ($urandom % 4) == 0,
             ($urandom % 10) == 0, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
